scr1_dmem_req_arb: RTL and testbench

SCR1_DMEM_REQ_ARB -- requirements
Module: scr1_dmem_req_arb

---
 rtl/scr1_dmem_arb_pkg.sv | 17 +
 rtl/scr1_memif_pkg.sv | 25 ++
 rtl/scr1_dmem_arb_idfifo.sv | 64 ++++++
 rtl/scr1_dmem_req_arb.sv | 149 ++++++++++++++
 tb/tb_scr1_dmem_req_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_dmem_arb_pkg.sv
// Shared types for the data-memory request arbiter.
// Requester IDs, routing-FIFO default depth, FSM states.
package scr1_dmem_arb_pkg;

  typedef logic type_scr1_arb_id_t;

  localparam type_scr1_arb_id_t SCR1_ARB_ID_LSU = 1'b0;
  localparam type_scr1_arb_id_t SCR1_ARB_ID_DMA = 1'b1;

  localparam int SCR1_ARB_OUTSTD_DFLT = 4;

  typedef enum logic {
    ARB_ST_ARB  = 1'b0,
    ARB_ST_HOLD = 1'b1
  } type_scr1_arb_fsm_e;

endpackage

// File: rtl/scr1_memif_pkg.sv
// Memory-interface types shared by the LSU, DMA and AHB bridge ports.
// Command, access width, response code and data-bus width.
package scr1_memif_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_arb_idfifo.sv
// Response-routing FIFO: remembers which requester owns each
// outstanding transfer. Pointers wrap modulo DEPTH.
module scr1_dmem_arb_idfifo
  import scr1_dmem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  type_scr1_arb_id_t id_i,
  input  logic              pop_i,
  output type_scr1_arb_id_t head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= ptr_inc(wp_q);
      if (do_pop)  rp_q <= ptr_inc(rp_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ID storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (do_push) begin
      mem_q[wp_q] <= id_i;
    end
  end

endmodule

// File: rtl/scr1_dmem_req_arb.sv
// Two-requester (LSU/DMA) data-memory arbiter with response routing.
// SCR1_DMEM_ARB_FIXED_PRIO_EN selects fixed LSU priority over round-robin.
module scr1_dmem_req_arb
  import scr1_memif_pkg::*;
  import scr1_dmem_arb_pkg::*;
#(
  parameter int SCR1_ARB_OUTSTD = SCR1_ARB_OUTSTD_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu_dmem_req,
  output logic                      lsu_dmem_req_ack,
  input  logic                      lsu_dmem_cmd,
  input  type_scr1_mem_width_e      lsu_dmem_width,
  input  logic [SCR1_AHB_WIDTH-1:0] lsu_dmem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] lsu_dmem_wdata,
  output logic [SCR1_AHB_WIDTH-1:0] lsu_dmem_rdata,
  output type_scr1_mem_resp_e       lsu_dmem_resp,
  input  logic                      dma_dmem_req,
  output logic                      dma_dmem_req_ack,
  input  logic                      dma_dmem_cmd,
  input  type_scr1_mem_width_e      dma_dmem_width,
  input  logic [SCR1_AHB_WIDTH-1:0] dma_dmem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] dma_dmem_wdata,
  output logic [SCR1_AHB_WIDTH-1:0] dma_dmem_rdata,
  output type_scr1_mem_resp_e       dma_dmem_resp,
  output logic                      dmem_req,
  output logic                      dmem_cmd,
  output type_scr1_mem_width_e      dmem_width,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_addr,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_wdata,
  input  logic                      dmem_req_ack,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_rdata,
  input  type_scr1_mem_resp_e       dmem_resp,
  output logic                      arb_err
);

  type_scr1_arb_fsm_e state_q;
  type_scr1_arb_id_t  sel_q;
  type_scr1_arb_id_t  sel;
  type_scr1_arb_id_t  head;
  logic               sel_req;
  logic               fifo_full;
  logic               fifo_empty;
  logic               resp_vld;
  logic               pop;
  logic               blk;
  logic               xfer;
  logic               err_q;
`ifndef SCR1_DMEM_ARB_FIXED_PRIO_EN
  type_scr1_arb_id_t  last_q;
`endif

  // Requester selection: held in HOLD, tie-break in ARB
  always_comb begin
    sel = SCR1_ARB_ID_LSU;
    if (state_q == ARB_ST_HOLD) begin
      sel = sel_q;
    end else if (lsu_dmem_req & dma_dmem_req) begin
`ifdef SCR1_DMEM_ARB_FIXED_PRIO_EN
      sel = SCR1_ARB_ID_LSU;
`else
      sel = ~last_q;
`endif
    end else if (dma_dmem_req) begin
      sel = SCR1_ARB_ID_DMA;
    end
  end

  assign resp_vld = (dmem_resp == SCR1_MEM_RESP_RDY_OK)
                  | (dmem_resp == SCR1_MEM_RESP_RDY_ER);
  assign pop      = resp_vld & ~fifo_empty;
  // A response retiring this cycle frees a slot for a new transfer
  assign blk      = fifo_full & ~pop;
  assign sel_req  = sel ? dma_dmem_req : lsu_dmem_req;
  assign dmem_req = sel_req & ~blk;
  assign xfer     = dmem_req & dmem_req_ack;

  assign dmem_cmd   = sel ? dma_dmem_cmd   : lsu_dmem_cmd;
  assign dmem_width = sel ? dma_dmem_width : lsu_dmem_width;
  assign dmem_addr  = sel ? dma_dmem_addr  : lsu_dmem_addr;
  assign dmem_wdata = sel ? dma_dmem_wdata : lsu_dmem_wdata;

  assign lsu_dmem_req_ack = xfer & (sel == SCR1_ARB_ID_LSU);
  assign dma_dmem_req_ack = xfer & (sel == SCR1_ARB_ID_DMA);

  assign lsu_dmem_rdata = dmem_rdata;
  assign dma_dmem_rdata = dmem_rdata;
  assign lsu_dmem_resp  = (pop & (head == SCR1_ARB_ID_LSU))
                        ? dmem_resp : SCR1_MEM_RESP_NOTRDY;
  assign dma_dmem_resp  = (pop & (head == SCR1_ARB_ID_DMA))
                        ? dmem_resp : SCR1_MEM_RESP_NOTRDY;
  assign arb_err        = err_q;

  // ARB/HOLD FSM: lock the selection while a request stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_ST_ARB;
      sel_q   <= SCR1_ARB_ID_LSU;
    end else begin
      unique case (state_q)
        ARB_ST_ARB: begin
          if (dmem_req & ~dmem_req_ack) begin
            state_q <= ARB_ST_HOLD;
            sel_q   <= sel;
          end
        end
        ARB_ST_HOLD: begin
          if (xfer) state_q <= ARB_ST_ARB;
        end
        default: state_q <= ARB_ST_ARB;
      endcase
    end
  end

`ifndef SCR1_DMEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer follows completed transfers only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SCR1_ARB_ID_DMA;
    end else if (xfer) begin
      last_q <= sel;
    end
  end
`endif

  // Sticky error for a response with nothing outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (resp_vld & fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  scr1_dmem_arb_idfifo #(
    .DEPTH (SCR1_ARB_OUTSTD)
  ) i_idfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (xfer),
    .id_i    (sel),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_scr1_dmem_req_arb.sv
// Directed self-checking bench for scr1_dmem_req_arb.
// Follows SCR1_DMEM_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_scr1_dmem_req_arb;
  import scr1_memif_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic lsu_req, lsu_ack, lsu_cmd;
  logic dma_req, dma_ack, dma_cmd;
  type_scr1_mem_width_e lsu_width, dma_width, d_width;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  type_scr1_mem_resp_e lsu_resp, dma_resp, d_resp;
  logic d_req, d_cmd, d_ack, err;
  logic [31:0] d_addr, d_wdata, d_rdata;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scr1_dmem_req_arb #(.SCR1_ARB_OUTSTD(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_dmem_req     (lsu_req),
    .lsu_dmem_req_ack (lsu_ack),
    .lsu_dmem_cmd     (lsu_cmd),
    .lsu_dmem_width   (lsu_width),
    .lsu_dmem_addr    (lsu_addr),
    .lsu_dmem_wdata   (lsu_wdata),
    .lsu_dmem_rdata   (lsu_rdata),
    .lsu_dmem_resp    (lsu_resp),
    .dma_dmem_req     (dma_req),
    .dma_dmem_req_ack (dma_ack),
    .dma_dmem_cmd     (dma_cmd),
    .dma_dmem_width   (dma_width),
    .dma_dmem_addr    (dma_addr),
    .dma_dmem_wdata   (dma_wdata),
    .dma_dmem_rdata   (dma_rdata),
    .dma_dmem_resp    (dma_resp),
    .dmem_req         (d_req),
    .dmem_cmd         (d_cmd),
    .dmem_width       (d_width),
    .dmem_addr        (d_addr),
    .dmem_wdata       (d_wdata),
    .dmem_req_ack     (d_ack),
    .dmem_rdata       (d_rdata),
    .dmem_resp        (d_resp),
    .arb_err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  localparam logic [31:0] NR = 32'(SCR1_MEM_RESP_NOTRDY);
  localparam logic [31:0] OK = 32'(SCR1_MEM_RESP_RDY_OK);
  localparam logic [31:0] ER = 32'(SCR1_MEM_RESP_RDY_ER);

  initial begin
    logic exp_dma;
    rst = 1'b1;
    lsu_req = 0; lsu_cmd = 0; lsu_width = SCR1_MEM_WIDTH_WORD;
    lsu_addr = 32'h100; lsu_wdata = 32'hAAAA_0001;
    dma_req = 0; dma_cmd = 1; dma_width = SCR1_MEM_WIDTH_BYTE;
    dma_addr = 32'h200; dma_wdata = 32'hBBBB_0002;
    d_ack = 0; d_rdata = 32'h0; d_resp = SCR1_MEM_RESP_NOTRDY;

    // reset state
    repeat (2) nxt();
    chk("rst_lsu_ack", 32'(lsu_ack), 0);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_dreq", 32'(d_req), 0);
    chk("rst_lsu_resp", 32'(lsu_resp), NR);
    chk("rst_dma_resp", 32'(dma_resp), NR);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    nxt();

    // simultaneous requests, ack=1: grant order
    lsu_req = 1; dma_req = 1; d_ack = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SCR1_DMEM_ARB_FIXED_PRIO_EN
      exp_dma = 1'b0;
`else
      exp_dma = (i % 2 == 1);
`endif
      smp();
      chk($sformatf("rr_addr%0d", i), d_addr, exp_dma ? 32'h200 : 32'h100);
      chk($sformatf("rr_lack%0d", i), 32'(lsu_ack), 32'(!exp_dma));
      chk($sformatf("rr_dack%0d", i), 32'(dma_ack), 32'(exp_dma));
      chk($sformatf("rr_cmd%0d", i), 32'(d_cmd), 32'(exp_dma));
      chk($sformatf("rr_wd%0d", i), d_wdata,
          exp_dma ? 32'hBBBB_0002 : 32'hAAAA_0001);
      nxt();
    end
    lsu_req = 0; dma_req = 0; d_ack = 0;
    d_resp = SCR1_MEM_RESP_RDY_OK;
    for (int i = 0; i < 4; i++) begin
`ifdef SCR1_DMEM_ARB_FIXED_PRIO_EN
      exp_dma = 1'b0;
`else
      exp_dma = (i % 2 == 1);
`endif
      d_rdata = 32'hC0DE_0000 + 32'(i);
      smp();
      chk($sformatf("rr_lresp%0d", i), 32'(lsu_resp), exp_dma ? NR : OK);
      chk($sformatf("rr_dresp%0d", i), 32'(dma_resp), exp_dma ? OK : NR);
      chk($sformatf("rr_rd%0d", i), lsu_rdata, 32'hC0DE_0000 + 32'(i));
      nxt();
    end
    d_resp = SCR1_MEM_RESP_NOTRDY;
    nxt();

    // dma held for 3 cycles without ack while lsu also asks
    dma_req = 1;
    smp();
    chk("hold_dreq", 32'(d_req), 1);
    chk("hold_addr0", d_addr, 32'h200);
    chk("hold_dack0", 32'(dma_ack), 0);
    nxt();
    lsu_req = 1;
    for (int i = 1; i < 3; i++) begin
      smp();
      chk($sformatf("hold_addr%0d", i), d_addr, 32'h200);
      chk($sformatf("hold_lack%0d", i), 32'(lsu_ack), 0);
      nxt();
    end
    d_ack = 1;
    smp();
    chk("hold_dack", 32'(dma_ack), 1);
    chk("hold_lack", 32'(lsu_ack), 0);
    nxt();
    smp();
    chk("hold_next_lack", 32'(lsu_ack), 1);
    chk("hold_next_addr", d_addr, 32'h100);
    nxt();
    lsu_req = 0; dma_req = 0; d_ack = 0;
    d_resp = SCR1_MEM_RESP_RDY_OK;
    smp();
    chk("hold_r0_dma", 32'(dma_resp), OK);
    chk("hold_r0_lsu", 32'(lsu_resp), NR);
    nxt();
    smp();
    chk("hold_r1_lsu", 32'(lsu_resp), OK);
    chk("hold_r1_dma", 32'(dma_resp), NR);
    nxt();
    d_resp = SCR1_MEM_RESP_NOTRDY;

    // fill the routing FIFO, then push+pop while full
    lsu_req = 1; d_ack = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("fill_lack%0d", i), 32'(lsu_ack), 1);
      nxt();
    end
    smp();
    chk("full_dreq", 32'(d_req), 0);
    chk("full_lack", 32'(lsu_ack), 0);
    nxt();
    d_resp = SCR1_MEM_RESP_RDY_OK;
    smp();
    chk("full_pp_dreq", 32'(d_req), 1);
    chk("full_pp_lack", 32'(lsu_ack), 1);
    chk("full_pp_resp", 32'(lsu_resp), OK);
    nxt();
    d_resp = SCR1_MEM_RESP_NOTRDY;
    smp();
    chk("still_full_dreq", 32'(d_req), 0);
    nxt();
    lsu_req = 0; d_ack = 0;
    d_resp = SCR1_MEM_RESP_RDY_OK;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("drain%0d", i), 32'(lsu_resp), OK);
      nxt();
    end
    d_resp = SCR1_MEM_RESP_NOTRDY;
    smp();
    chk("drain_err", 32'(err), 0);
    nxt();

    // error response on a dma read
    dma_req = 1; dma_cmd = 0; d_ack = 1;
    smp();
    chk("er_dack", 32'(dma_ack), 1);
    nxt();
    dma_req = 0; d_ack = 0;
    d_resp = SCR1_MEM_RESP_RDY_ER; d_rdata = 32'h0BAD_F00D;
    smp();
    chk("er_dma", 32'(dma_resp), ER);
    chk("er_lsu", 32'(lsu_resp), NR);
    chk("er_rd", dma_rdata, 32'h0BAD_F00D);
    nxt();

    // response with nothing outstanding
    d_resp = SCR1_MEM_RESP_RDY_OK;
    smp();
    chk("emp_lsu", 32'(lsu_resp), NR);
    chk("emp_dma", 32'(dma_resp), NR);
    chk("emp_err_pre", 32'(err), 0);
    nxt();
    d_resp = SCR1_MEM_RESP_NOTRDY;
    chk("emp_err_set", 32'(err), 1);
    repeat (3) nxt();
    chk("emp_err_sticky", 32'(err), 1);
    rst = 1'b1;
    #1;
    chk("emp_err_clr", 32'(err), 0);
    nxt();
    rst = 1'b0;
    nxt();

    // reset mid-operation drops outstanding entries
    lsu_req = 1; d_ack = 1;
    smp();
    chk("mid_lack", 32'(lsu_ack), 1);
    nxt();
    lsu_req = 0; d_ack = 0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    nxt();
    d_resp = SCR1_MEM_RESP_RDY_OK;
    smp();
    chk("mid_lsu_resp", 32'(lsu_resp), NR);
    nxt();
    d_resp = SCR1_MEM_RESP_NOTRDY;
    chk("mid_err", 32'(err), 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
